// File: rtl/vram_fill.sv
`default_nettype none
// ============================================================================
// Module      : vram_fill
// Description : Command-driven rectangle fill engine. Writes a solid 3-bit
//               colour into a 256x256 VRAM at one pixel per clock. Commands
//               arrive through a small FIFO with a valid/ready handshake.
//               A command may wait for the start of vertical sync so that
//               the fill does not tear against the scan-out.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK          in   1  system / pixel clock
//   I_RESET      in   1  asynchronous active-high reset
//   I_CMD_VALID  in   1  command present
//   O_CMD_READY  out  1  command FIFO not full
//   I_CMD_X      in   8  left column X0
//   I_CMD_Y      in   8  top row Y0
//   I_CMD_W      in   9  width in pixels (0 = no-op)
//   I_CMD_H      in   9  height in pixels (0 = no-op)
//   I_CMD_COLOR  in   3  fill colour {G,B,R}
//   I_CMD_SYNC   in   1  wait for VSYNC falling edge before writing
//   I_VSYNC      in   1  active-low vertical sync from scan-out
//   O_VRAM_WE    out  1  write strobe
//   O_VRAM_ADDR  out 16  {row, col}
//   O_VRAM_DATA  out  3  pixel data (0 when not writing)
//   O_BUSY       out  1  FIFO non-empty or engine not idle
//   O_DONE       out  1  one-cycle pulse per completed command
// ============================================================================
module vram_fill #(
    parameter int CMD_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        I_RESET,
    input  logic        I_CMD_VALID,
    output logic        O_CMD_READY,
    input  logic [7:0]  I_CMD_X,
    input  logic [7:0]  I_CMD_Y,
    input  logic [8:0]  I_CMD_W,
    input  logic [8:0]  I_CMD_H,
    input  logic [2:0]  I_CMD_COLOR,
    input  logic        I_CMD_SYNC,
    input  logic        I_VSYNC,
    output logic        O_VRAM_WE,
    output logic [15:0] O_VRAM_ADDR,
    output logic [2:0]  O_VRAM_DATA,
    output logic        O_BUSY,
    output logic        O_DONE
);

    localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = 38;   // {X, Y, W, H, COLOR, SYNC}

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_FILL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO. Pointers carry one extra wrap bit so that full and
    // empty are distinguishable without a separate counter.
    // ------------------------------------------------------------------
    logic [CW-1:0] fifo_mem [CMD_DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW-1:0] head;

    state_t        state_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign fifo_push  = I_CMD_VALID && !fifo_full;
    assign fifo_pop   = (state_q == S_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {I_CMD_X, I_CMD_Y, I_CMD_W, I_CMD_H,
                                           I_CMD_COLOR, I_CMD_SYNC};
        end
    end

    always_ff @(posedge CLK or posedge I_RESET) begin
        if (I_RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head-of-queue decode and clipping to the 256x256 screen.
    // ------------------------------------------------------------------
    logic [7:0] h_x;
    logic [7:0] h_y;
    logic [8:0] h_w;
    logic [8:0] h_h;
    logic [2:0] h_color;
    logic       h_sync;
    logic [8:0] rem_x;
    logic [8:0] rem_y;
    logic [8:0] clip_w;
    logic [8:0] clip_h;
    logic [7:0] last_x_d;
    logic [7:0] last_y_d;
    logic       h_noop;

    assign {h_x, h_y, h_w, h_h, h_color, h_sync} = head;

    assign rem_x  = 9'd256 - {1'b0, h_x};
    assign rem_y  = 9'd256 - {1'b0, h_y};
    assign clip_w = (h_w < rem_x) ? h_w : rem_x;
    assign clip_h = (h_h < rem_y) ? h_h : rem_y;
    assign h_noop = (h_w == 9'd0) || (h_h == 9'd0);

    // X0 + Wc - 1 never exceeds 255, so modulo-256 arithmetic is exact even
    // when Wc == 256 (its low byte is 0 and X0 must be 0).
    assign last_x_d = h_x + clip_w[7:0] - 8'd1;
    assign last_y_d = h_y + clip_h[7:0] - 8'd1;

    // ------------------------------------------------------------------
    // Fill state machine.
    // ------------------------------------------------------------------
    logic       vs_q;
    logic [7:0] cur_x_q;
    logic [7:0] cur_y_q;
    logic [7:0] x0_q;
    logic [7:0] last_x_q;
    logic [7:0] last_y_q;
    logic [2:0] color_q;

    always_ff @(posedge CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q  <= S_IDLE;
            vs_q     <= 1'b1;
            cur_x_q  <= 8'd0;
            cur_y_q  <= 8'd0;
            x0_q     <= 8'd0;
            last_x_q <= 8'd0;
            last_y_q <= 8'd0;
            color_q  <= 3'd0;
        end else begin
            vs_q <= I_VSYNC;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cur_x_q  <= h_x;
                        cur_y_q  <= h_y;
                        x0_q     <= h_x;
                        last_x_q <= last_x_d;
                        last_y_q <= last_y_d;
                        color_q  <= h_color;
                        if (h_noop) begin
                            state_q <= S_DONE;
                        end else if (h_sync) begin
                            state_q <= S_WAIT_VS;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_WAIT_VS: begin
                    // vs_q tracks VSYNC from the pop cycle onward, so an edge
                    // seen before this state was entered cannot trigger here.
                    if (vs_q && !I_VSYNC) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (cur_x_q == last_x_q) begin
                        if (cur_y_q == last_y_q) begin
                            state_q <= S_DONE;
                        end else begin
                            cur_x_q <= x0_q;
                            cur_y_q <= cur_y_q + 8'd1;
                        end
                    end else begin
                        cur_x_q <= cur_x_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded directly from registered state.
    // ------------------------------------------------------------------
    assign O_CMD_READY = !fifo_full;
    assign O_VRAM_WE   = (state_q == S_FILL);
    assign O_VRAM_ADDR = {cur_y_q, cur_x_q};
    assign O_VRAM_DATA = O_VRAM_WE ? color_q : 3'd0;
    assign O_DONE      = (state_q == S_DONE);
    assign O_BUSY      = !fifo_empty || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vram_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_fill
// Description : Self-checking bench for vram_fill. An event-queue model of
//               the expected pixel writes and done pulses is built from each
//               accepted command; a compare process matches it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_fill;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [8:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [2:0]  cmd_color;
    logic        cmd_sync;
    logic        vsync;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [2:0]  vram_data;
    logic        busy;
    logic        done;

    vram_fill #(.CMD_DEPTH(DEPTH)) dut (
        .CLK         (clk),
        .I_RESET     (rst),
        .I_CMD_VALID (cmd_valid),
        .O_CMD_READY (cmd_ready),
        .I_CMD_X     (cmd_x),
        .I_CMD_Y     (cmd_y),
        .I_CMD_W     (cmd_w),
        .I_CMD_H     (cmd_h),
        .I_CMD_COLOR (cmd_color),
        .I_CMD_SYNC  (cmd_sync),
        .I_VSYNC     (vsync),
        .O_VRAM_WE   (vram_we),
        .O_VRAM_ADDR (vram_addr),
        .O_VRAM_DATA (vram_data),
        .O_BUSY      (busy),
        .O_DONE      (done)
    );

    always #5 clk = ~clk;

    // Expected event: a pixel write or a done pulse. 'must' marks events that
    // have to occur in the cycle right after the previous event (no gaps).
    typedef struct packed {
        logic        is_done;
        logic        must;
        logic [15:0] addr;
        logic [2:0]  data;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] obs_addr[$];
    logic [2:0]  obs_data[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          wr_count = 0;
    int          done_count = 0;

    logic [15:0] lit_t1 [6] = '{16'h140A, 16'h140B, 16'h140C,
                                16'h150A, 16'h150B, 16'h150C};
    logic [15:0] lit_clip [2] = '{16'hFFFE, 16'hFFFF};

    function automatic void chk(input bit ok, input string name,
                                input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_err++;
            if (n_err <= 30) begin
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
            end
        end
    endfunction

    // Model: raster-order pixel list, clipped at the screen edge.
    function automatic void model_add(input int x, input int y, input int w,
                                      input int h, input int c);
        int  n = 0;
        ev_t ev;
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                if ((x + k) <= 255 && (y + r) <= 255) begin
                    ev.is_done = 1'b0;
                    ev.must    = (n != 0);
                    ev.addr    = 16'((y + r) * 256 + (x + k));
                    ev.data    = 3'(c);
                    exp_q.push_back(ev);
                    n++;
                end
            end
        end
        ev.is_done = 1'b1;
        ev.must    = (n != 0);
        ev.addr    = 16'd0;
        ev.data    = 3'd0;
        exp_q.push_back(ev);
    endfunction

    // Compare process
    always @(negedge clk) begin : cmp
        ev_t e;
        if (!rst) begin
            if (!vram_we) begin
                chk(vram_data == 3'd0, "data_zero_when_idle", vram_data, 0);
            end
            if (vram_we && done) begin
                chk(1'b0, "we_and_done_together", 1, 0);
            end else if (vram_we || done) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, done ? "unexpected_done" : "unexpected_write",
                        vram_addr, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (vram_we) begin
                        chk(!e.is_done && vram_addr == e.addr && vram_data == e.data,
                            "write_addr_data", {e.is_done, vram_addr, vram_data},
                            {1'b0, e.addr, e.data});
                        obs_addr.push_back(vram_addr);
                        obs_data.push_back(vram_data);
                        wr_count++;
                    end else begin
                        chk(e.is_done, "done_order", 1, e.is_done);
                        done_count++;
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].must) begin
                chk(1'b0, "gap_before_expected_event", 0, exp_q[0].addr);
            end
        end
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y,
                        input logic [8:0] w, input logic [8:0] h,
                        input logic [2:0] c, input logic s, output int waits);
        waits = 0;
        @(negedge clk);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h;
        cmd_color = c; cmd_sync = s; cmd_valid = 1'b1;
        while (!cmd_ready && waits < 500) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) begin
            chk(1'b0, "ready_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_add(int'(x), int'(y), int'(w), int'(h), int'(c));
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic first_event(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(vram_we || done) && cyc < 300);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(!busy && exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int wa, wb, cyc, base, wbase, dbase;
        bit busy_ok, we_seen;

        rst = 1'b1; cmd_valid = 1'b0; vsync = 1'b1;
        cmd_x = 0; cmd_y = 0; cmd_w = 0; cmd_h = 0; cmd_color = 0; cmd_sync = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk(cmd_ready == 1'b1, "reset_ready", cmd_ready, 1);
        chk(vram_we == 1'b0, "reset_we", vram_we, 0);
        chk(vram_addr == 16'h0, "reset_addr", vram_addr, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(done == 1'b0, "reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk(cmd_ready && !busy, "post_reset_ready_busy", {cmd_ready, busy}, 2'b10);

        // Basic 3x2 rectangle
        base = obs_addr.size(); dbase = done_count;
        send(8'd10, 8'd20, 9'd3, 9'd2, 3'd5, 1'b0, wa);
        first_event(cyc);
        chk(cyc == 2, "t1_first_we_latency", cyc, 2);
        wait_idle(100);
        chk(obs_addr.size() - base == 6, "t1_write_count", obs_addr.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < obs_addr.size()) begin
                chk(obs_addr[base + i] == lit_t1[i] && obs_data[base + i] == 3'd5,
                    "t1_literal_addr", obs_addr[base + i], lit_t1[i]);
            end
        end
        chk(done_count - dbase == 1, "t1_done_count", done_count - dbase, 1);

        // Clipped rectangle at the bottom-right corner
        base = obs_addr.size();
        send(8'd254, 8'd255, 9'd5, 9'd300, 3'd2, 1'b0, wa);
        wait_idle(100);
        chk(obs_addr.size() - base == 2, "clip_write_count", obs_addr.size() - base, 2);
        for (int i = 0; i < 2; i++) begin
            if (base + i < obs_addr.size()) begin
                chk(obs_addr[base + i] == lit_clip[i], "clip_literal_addr",
                    obs_addr[base + i], lit_clip[i]);
            end
        end

        // No-op command
        wbase = wr_count;
        send(8'd5, 8'd5, 9'd0, 9'd7, 3'd1, 1'b0, wa);
        first_event(cyc);
        chk(cyc == 2 && done, "noop_done_latency", cyc, 2);
        wait_idle(50);
        chk(wr_count == wbase, "noop_no_writes", wr_count - wbase, 0);

        // FIFO fill: one long command running, DEPTH more queue up, one stalls
        send(8'd0, 8'd100, 9'd20, 9'd1, 3'd4, 1'b0, wa);
        wb = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send(8'(1 + i), 8'(101 + i), 9'd3, 9'd2, 3'(6 + i), 1'b0, wa);
            wb += wa;
        end
        chk(wb == 0, "fifo_accept_without_stall", wb, 0);
        chk(cmd_ready == 1'b0, "ready_low_when_full", cmd_ready, 0);
        send(8'd9, 8'd110, 9'd4, 9'd1, 3'd1, 1'b0, wa);
        chk(wa > 0, "push_stalled_while_full", wa, 1);
        wait_idle(300);

        // VSYNC-synchronised command
        vsync = 1'b1;
        send(8'd50, 8'd60, 9'd2, 9'd2, 3'd3, 1'b1, wa);
        busy_ok = 1'b1; we_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (vram_we) we_seen = 1'b1;
            if (!busy) busy_ok = 1'b0;
        end
        chk(!we_seen, "sync_no_write_before_vsync", we_seen, 0);
        chk(busy_ok, "sync_busy_while_waiting", busy_ok, 1);
        vsync = 1'b0;
        @(negedge clk);
        chk(vram_we && vram_addr == 16'h3C32, "sync_first_we_after_fall",
            {vram_we, vram_addr}, {1'b1, 16'h3C32});
        wait_idle(50);
        vsync = 1'b1;

        // Reset during FILL
        send(8'd0, 8'd0, 9'd200, 9'd200, 3'd6, 1'b0, wa);
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk(vram_we == 1'b0, "reset_mid_fill_we", vram_we, 0);
        chk(busy == 1'b0, "reset_mid_fill_busy", busy, 0);
        chk(cmd_ready && vram_addr == 16'h0, "reset_mid_fill_ready_addr",
            {cmd_ready, vram_addr}, {1'b1, 16'h0});
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;

        // Full-screen clear
        base = obs_addr.size(); wbase = wr_count; dbase = done_count;
        send(8'd0, 8'd0, 9'd256, 9'd256, 3'd3, 1'b0, wa);
        first_event(cyc);
        chk(cyc == 2, "clear_first_we_latency", cyc, 2);
        wait_idle(70000);
        chk(wr_count - wbase == 65536, "clear_write_count", wr_count - wbase, 65536);
        chk(done_count - dbase == 1, "clear_done_count", done_count - dbase, 1);
        if (obs_addr.size() == base + 65536) begin
            chk(obs_addr[base] == 16'h0000 && obs_addr[base + 65535] == 16'hFFFF,
                "clear_first_last_addr", {obs_addr[base], obs_addr[base + 65535]},
                32'h0000FFFF);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_fill.md
# vram_fill

Command-driven rectangle fill engine that writes solid 3-bit colours into the 256x256 VRAM, one pixel per clock. It owns the VRAM write port; the VGA scan-out stage owns the read port of the same dual-port RAM. Commands come from the CPU-side register block through a small FIFO with a valid/ready handshake. A command can optionally hold off until the start of vertical sync, giving tear-free clears.

## Interface
- CMD_DEPTH, 2, command FIFO depth; power of two, 2..8
- CLK  in  1  system clock (pixel clock domain, same as scan-out)
- I_RESET  in  1  asynchronous, active-high reset
- I_CMD_VALID  in  1  command present
- O_CMD_READY  out  1  FIFO not full; a command is accepted on a rising edge with VALID&&READY
- I_CMD_X  in  8  left column X0
- I_CMD_Y  in  8  top row Y0
- I_CMD_W  in  9  width in pixels; 0 = no-op
- I_CMD_H  in  9  height in pixels; 0 = no-op
- I_CMD_COLOR  in  3  fill colour, bit0=R, bit1=B, bit2=G
- I_CMD_SYNC  in  1  1 = wait for the VSYNC falling edge before writing
- I_VSYNC  in  1  active-low vertical sync from the scan-out stage
- O_VRAM_WE  out  1  write strobe, one pixel per cycle
- O_VRAM_ADDR  out  16  {row[7:0], col[7:0]}, i.e. row*256+col
- O_VRAM_DATA  out  3  pixel data
- O_BUSY  out  1  FIFO non-empty or FSM not IDLE
- O_DONE  out  1  one-cycle pulse per completed command, including no-ops

## Operation
- FIFO: CMD_DEPTH entries of {X,Y,W,H,COLOR,SYNC}. READY = !full. A push and a pop can happen in the same cycle; with READY low, no push occurs even if a pop happens that cycle.
- FSM states: IDLE, WAIT_VS, FILL, DONE.
- IDLE with FIFO non-empty: pop and latch the command.
  - W==0 or H==0: go to DONE.
  - SYNC=1: go to WAIT_VS.
  - Otherwise: go to FILL.
- WAIT_VS: vs_q registers I_VSYNC every cycle. Falling edge = vs_q && !I_VSYNC. Move to FILL on the edge where the falling edge is detected. A falling edge that occurred before entry does not count.
- FILL: cur_x starts at X0 and cur_y at Y0. Order is raster, x inner.
- Clipping: Wc = min(W, 256-X0) and Hc = min(H, 256-Y0), computed 9-bit with no wrap. W or H >256 therefore clips to the screen edge. Columns and rows past 255 are never written.
- In FILL, the cycle with cur_x==X0+Wc-1 and cur_y==Y0+Hc-1 is the last write; move to DONE.
- DONE lasts one cycle with O_DONE=1, then IDLE.
- O_VRAM_WE = (state==FILL). O_VRAM_ADDR = {cur_y,cur_x}. O_VRAM_DATA = latched colour, driven only while WE=1, else 0.
- Exactly Wc*Hc write cycles per command, with no gaps.

## Timing
- Reset (async, any state): FIFO flushed, state IDLE, vs_q=1, cur_x=cur_y=0.
- Output values in reset: O_CMD_READY=1, O_VRAM_WE=0, O_VRAM_ADDR=0, O_VRAM_DATA=0, O_BUSY=0, O_DONE=0.
- Reset during FILL: writes stop immediately and the partial rectangle is left as is.
- Latency, command handshaken in cycle c with FSM idle and FIFO empty:
  - cycle c+1: pop, FSM goes to FILL at the end of the cycle;
  - cycle c+2: first WE.
  - For SYNC commands, first WE falls in the cycle after the detecting edge.
- Last write in cycle e: O_DONE in cycle e+1, IDLE in e+2, next command's earliest first WE in e+3.
- O_BUSY falls in the first IDLE cycle with the FIFO empty.
- Throughput: 1 pixel/clock. A full-screen clear takes 65536 write cycles plus 3 overhead.

## Test plan
- Reset release -> READY=1, WE=0, ADDR=0, BUSY=0. Assert I_RESET mid-FILL -> WE=0 asynchronously, BUSY=0.
- Command X=10,Y=20,W=3,H=2,COLOR=5 -> 6 writes, data 5, addresses 0x140A,0x140B,0x140C,0x150A,0x150B,0x150C. First WE 2 cycles after handshake, DONE 1 cycle after last write.
- Clip: X=254,Y=255,W=5,H=300 -> writes only 0xFFFE and 0xFFFF, then DONE.
- No-op: W=0 -> zero WE cycles, DONE pulse 2 cycles after handshake. Push CMD_DEPTH+1 commands back-to-back -> READY low after CMD_DEPTH pushes, all commands executed in order.
- SYNC=1 with I_VSYNC held high for 100 cycles -> no WE, BUSY=1. Drive I_VSYNC low -> first WE in the following cycle.
- Full-screen clear X=0,Y=0,W=256,H=256 -> 65536 consecutive WE cycles, addresses 0x0000..0xFFFF in order, one DONE pulse.
